// File: rtl/msp430_ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// msp430_ram_arb_pkg
// Shared types and constants for the MSP430 RAM arbiter (CPU vs DMA).
//   req_id_t     : requester identity (CPU, DMA), used for last_gnt tracking
//   arb_state_t  : arbiter state encoding (IDLE, LOCK_CPU, LOCK_DMA)
//   RD_WEN       : byte write-enable pattern (active low) that means "read"
//   GNT_CPU/DMA  : bit positions inside the one-hot grant vector
// Optional feature macro used by the arbiter: RAM_ARB_LOCK_EN
// ----------------------------------------------------------------------------
package msp430_ram_arb_pkg;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCK_CPU = 2'd1,
        ST_LOCK_DMA = 2'd2
    } arb_state_t;

    localparam logic [1:0] RD_WEN  = 2'b11;

    localparam int GNT_CPU = 0;
    localparam int GNT_DMA = 1;

    // An access is a read only when neither byte lane is write-enabled.
    function automatic logic is_read(input logic [1:0] wen);
        return (wen == RD_WEN);
    endfunction

endpackage

// File: rtl/msp430_ram_arb_rr.sv
// ----------------------------------------------------------------------------
// msp430_ram_arb_rr
// Purely combinational round-robin pick between the CPU and DMA requesters.
// Ports:
//   cpu_req, dma_req : access requests
//   last_gnt         : requester granted most recently
//   lock_state       : arbiter state; a LOCK_* state restricts the grant to
//                      the lock owner
//   gnt_oh           : one-hot grant, bit GNT_CPU / bit GNT_DMA
// ----------------------------------------------------------------------------
module msp430_ram_arb_rr
    import msp430_ram_arb_pkg::*;
(
    input  logic       cpu_req,
    input  logic       dma_req,
    input  req_id_t    last_gnt,
    input  arb_state_t lock_state,
    output logic [1:0] gnt_oh
);

    always_comb begin
        gnt_oh = 2'b00;
        case (lock_state)
            // Locked: the owner is the only candidate; the other side stalls.
            ST_LOCK_CPU: gnt_oh[GNT_CPU] = cpu_req;
            ST_LOCK_DMA: gnt_oh[GNT_DMA] = dma_req;
            default: begin
                if (cpu_req && dma_req) begin
                    // Contention: whoever was not served last goes first.
                    if (last_gnt == REQ_DMA) gnt_oh[GNT_CPU] = 1'b1;
                    else                     gnt_oh[GNT_DMA] = 1'b1;
                end else if (cpu_req) begin
                    gnt_oh[GNT_CPU] = 1'b1;
                end else if (dma_req) begin
                    gnt_oh[GNT_DMA] = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/msp430_ram_arbiter.sv
// ----------------------------------------------------------------------------
// msp430_ram_arbiter
// Shares one single-port MSP430 data RAM between the CPU and a DMA engine.
// The grant is combinational in the request cycle; read data comes back one
// cycle later and is steered to the requester that issued the read.
//
// Parameters:
//   ADDR_MSB : MSB of the RAM word address
//   MEM_SIZE : RAM size in bytes (word depth MEM_SIZE/2)
// Ports:
//   mclk, puc_rst                       : clock, async active-high reset
//   cpu_req/addr/wen/din/lock           : CPU request side (wen active low)
//   cpu_gnt, cpu_dout, cpu_dout_vld     : CPU grant and read response
//   dma_*                               : same set for the DMA requester
//   ram_addr/cen/wen/din, ram_dout      : RAM macro interface
//
// Optional feature: define RAM_ARB_LOCK_EN to let a requester hold the RAM
// across consecutive cycles with its *_lock input. Without it the lock inputs
// are ignored and the arbiter stays in IDLE.
// ----------------------------------------------------------------------------
module msp430_ram_arbiter
    import msp430_ram_arb_pkg::*;
#(
    parameter int ADDR_MSB = 6,
    parameter int MEM_SIZE = 256
) (
    input  logic                mclk,
    input  logic                puc_rst,

    input  logic                cpu_req,
    input  logic [ADDR_MSB:0]   cpu_addr,
    input  logic [1:0]          cpu_wen,
    input  logic [15:0]         cpu_din,
    input  logic                cpu_lock,
    output logic                cpu_gnt,
    output logic [15:0]         cpu_dout,
    output logic                cpu_dout_vld,

    input  logic                dma_req,
    input  logic [ADDR_MSB:0]   dma_addr,
    input  logic [1:0]          dma_wen,
    input  logic [15:0]         dma_din,
    input  logic                dma_lock,
    output logic                dma_gnt,
    output logic [15:0]         dma_dout,
    output logic                dma_dout_vld,

    output logic [ADDR_MSB:0]   ram_addr,
    output logic                ram_cen,
    output logic [1:0]          ram_wen,
    output logic [15:0]         ram_din,
    input  logic [15:0]         ram_dout
);

    localparam int unsigned MEM_DEPTH = MEM_SIZE / 2;

    arb_state_t state_q,    state_d;
    req_id_t    last_gnt_q, last_gnt_d;
    logic       cpu_vld_q,  cpu_vld_d;
    logic       dma_vld_q,  dma_vld_d;
    logic       oor_q,      oor_d;

    logic [1:0]        gnt_oh;
    logic              any_gnt;
    logic [ADDR_MSB:0] win_addr;
    logic [1:0]        win_wen;
    logic [15:0]       win_din;
    logic              win_oor;

    msp430_ram_arb_rr u_rr (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .last_gnt   (last_gnt_q),
        .lock_state (state_q),
        .gnt_oh     (gnt_oh)
    );

    // No grant may leave the arbiter while reset is held.
    assign cpu_gnt = gnt_oh[GNT_CPU] & ~puc_rst;
    assign dma_gnt = gnt_oh[GNT_DMA] & ~puc_rst;
    assign any_gnt = cpu_gnt | dma_gnt;

    // ------------------------------------------------------------------
    // Request cycle: winner mux and RAM drive
    // ------------------------------------------------------------------
    always_comb begin
        win_addr = dma_gnt ? dma_addr : cpu_addr;
        win_wen  = dma_gnt ? dma_wen  : cpu_wen;
        win_din  = dma_gnt ? dma_din  : cpu_din;
        win_oor  = (32'(win_addr) >= MEM_DEPTH);

        ram_addr = any_gnt ? win_addr : '0;
        ram_din  = any_gnt ? win_din  : 16'h0000;
        ram_wen  = any_gnt ? win_wen  : RD_WEN;
        // Out-of-range accesses are granted but never reach the RAM.
        ram_cen  = ~(any_gnt & ~win_oor);
    end

    // ------------------------------------------------------------------
    // Next-state: response tracking, round-robin history, lock FSM
    // ------------------------------------------------------------------
    always_comb begin
        cpu_vld_d  = cpu_gnt & is_read(win_wen);
        dma_vld_d  = dma_gnt & is_read(win_wen);
        oor_d      = any_gnt & win_oor;

        last_gnt_d = last_gnt_q;
        if (cpu_gnt)      last_gnt_d = REQ_CPU;
        else if (dma_gnt) last_gnt_d = REQ_DMA;

`ifdef RAM_ARB_LOCK_EN
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_gnt && cpu_lock)      state_d = ST_LOCK_CPU;
                else if (dma_gnt && dma_lock) state_d = ST_LOCK_DMA;
            end
            // The lock ends in the first owner cycle that either drops the
            // request or stops asserting lock; that cycle still belongs to
            // the owner.
            ST_LOCK_CPU: begin
                if (!cpu_req || !cpu_lock) state_d = ST_IDLE;
            end
            ST_LOCK_DMA: begin
                if (!dma_req || !dma_lock) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`else
        state_d = ST_IDLE;
`endif
    end

`ifndef RAM_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = cpu_lock ^ dma_lock;
`endif

    // ------------------------------------------------------------------
    // Response cycle: state registers
    // ------------------------------------------------------------------
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= REQ_DMA;
            cpu_vld_q  <= 1'b0;
            dma_vld_q  <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cpu_vld_q  <= cpu_vld_d;
            dma_vld_q  <= dma_vld_d;
            oor_q      <= oor_d;
        end
    end

    // Read data is routed only to the requester that owns the response;
    // an out-of-range read returns zero because the RAM was never enabled.
    assign cpu_dout_vld = cpu_vld_q;
    assign dma_dout_vld = dma_vld_q;
    assign cpu_dout     = (cpu_vld_q && !oor_q) ? ram_dout : 16'h0000;
    assign dma_dout     = (dma_vld_q && !oor_q) ? ram_dout : 16'h0000;

endmodule
